// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and constants.
package fetch_stage_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StHold = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    // Driven on instra whenever no instruction is being presented.
    localparam logic [31:0] INSTR_ZERO       = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/fetch_hold_buf.sv
// Holds one fetched instruction and its pc+4 while the decode side is stalled.
module fetch_hold_buf
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4
);

    logic [31:0] instr_q;
    logic [31:0] pc_plus4_q;

    // Capture on load; clear wins so a consumed/discarded entry never lingers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= INSTR_ZERO;
            pc_plus4_q <= '0;
        end else if (clear) begin
            instr_q    <= INSTR_ZERO;
            pc_plus4_q <= '0;
        end else if (load) begin
            instr_q    <= instr_in;
            pc_plus4_q <= pc_plus4_in;
        end
    end

    assign instr    = instr_q;
    assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, picks sequential or redirect next PC and runs a
// single-outstanding request/response handshake to instruction memory.
// Optional feature macro FETCH_MISALIGN_CHK_EN adds the fetch_misalign output and forces
// redirect targets to word alignment.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_f,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instra,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        fetch_stall
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        fetch_misalign
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         drop_q, drop_d;

    logic [31:0]  pc_seq;
    logic [31:0]  redirect_pc;
    logic         hold_load, hold_clear;
    logic [31:0]  hold_instr, hold_pc_plus4;
    logic         present_valid;
    logic [31:0]  present_instr, present_pc4;

    assign pc_seq = pc_q + PC_STEP;

`ifdef FETCH_MISALIGN_CHK_EN
    assign redirect_pc = {pc_target_e[31:2], 2'b00};

    logic misalign_q;

    // Flag a redirect whose target was not word aligned, one cycle after the redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= pc_src_e & (|pc_target_e[1:0]);
        end
    end

    assign fetch_misalign = misalign_q;
`else
    assign redirect_pc = pc_target_e;
`endif

    // State, PC and stale-response flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state, PC select and the instruction being presented this cycle.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        hold_load     = 1'b0;
        hold_clear    = 1'b0;
        present_valid = 1'b0;
        present_instr = INSTR_ZERO;
        present_pc4   = '0;
        case (state_q)
            StIdle: begin
                state_d = StReq;
                if (pc_src_e) pc_d = redirect_pc;
            end
            StReq: begin
                if (imem_ready) state_d = StWait;
                if (pc_src_e) begin
                    pc_d = redirect_pc;
                    // The request just accepted is for the old PC.
                    if (imem_ready) drop_d = 1'b1;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    state_d = StReq;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else begin
                        present_valid = 1'b1;
                        present_instr = imem_rdata;
                        present_pc4   = pc_seq;
                        if (!pc_src_e && stall_f) begin
                            hold_load = 1'b1;
                            state_d   = StHold;
                        end
                    end
                    if (pc_src_e) begin
                        pc_d = redirect_pc;
                    end else if (!drop_q && !stall_f) begin
                        pc_d = pc_seq;
                    end
                end else if (pc_src_e) begin
                    // Response still in flight: remember to discard it.
                    pc_d   = redirect_pc;
                    drop_d = 1'b1;
                end
            end
            StHold: begin
                present_valid = 1'b1;
                present_instr = hold_instr;
                present_pc4   = hold_pc_plus4;
                if (pc_src_e) begin
                    pc_d       = redirect_pc;
                    state_d    = StReq;
                    hold_clear = 1'b1;
                end else if (!stall_f) begin
                    pc_d       = pc_seq;
                    state_d    = StReq;
                    hold_clear = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    fetch_hold_buf u_hold_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (hold_load),
        .clear       (hold_clear),
        .instr_in    (imem_rdata),
        .pc_plus4_in (pc_seq),
        .instr       (hold_instr),
        .pc_plus4    (hold_pc_plus4)
    );

    // Redirect squashes whatever is being presented.
    assign instr_valid = present_valid & ~pc_src_e;
    assign instra      = instr_valid ? present_instr : INSTR_ZERO;
    assign pc_plus4    = instr_valid ? present_pc4 : 32'h0;
    assign fetch_stall = ~instr_valid;

    // Request side decodes registered state only.
    assign imem_req  = (state_q == StReq);
    assign imem_addr = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized memory latency,
// stalls and redirects checked by a transaction-level reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_f = 1'b0;
    logic        pc_src_e = 1'b0;
    logic [31:0] pc_target_e = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instra;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        fetch_stall;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_misalign;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    // Memory model state
    logic        mem_pending = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        fixed_en = 1'b0;
    logic [31:0] fixed_word = '0;

    // Reference model: address of the next instruction the program should see
    logic [31:0] exp_pc = '0;
    int          consumed = 0;

    // Samples of the last step
    logic        s_req, s_valid, s_fstall;
    logic [31:0] s_addr, s_instra, s_pc4;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_f     (stall_f),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instra      (instra),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid),
        .fetch_stall (fetch_stall)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    // Distinct word per address so a stale response is always detectable.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return fixed_en ? fixed_word : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endfunction

    function automatic logic [31:0] target_pc(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHK_EN
        return {t[31:2], 2'b00};
`else
        return t;
`endif
    endfunction

    // One clock: drive at negedge, sample 1ns later, score, then advance to next negedge.
    task automatic step(input logic stall, input logic redir, input logic [31:0] tgt,
                        input int rdy_pct, input int rv_pct);
        stall_f     = stall;
        pc_src_e    = redir;
        pc_target_e = tgt;
        imem_ready  = ($urandom_range(99) < rdy_pct);
        if (mem_pending && ($urandom_range(99) < rv_pct)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        s_req    = imem_req;
        s_addr   = imem_addr;
        s_valid  = instr_valid;
        s_instra = instra;
        s_pc4    = pc_plus4;
        s_fstall = fetch_stall;

        n_cmp++;
        if (s_fstall !== ~s_valid) begin
            n_fail++;
            $display("FAIL sb_fetch_stall: got %b expected %b", s_fstall, ~s_valid);
        end
        if (s_valid === 1'b1) begin
            n_cmp++;
            if (s_instra !== mem_word(exp_pc) || s_pc4 !== exp_pc + 32'd4) begin
                n_fail++;
                $display("FAIL sb_instr: got %h/%h expected %h/%h", s_instra, s_pc4,
                         mem_word(exp_pc), exp_pc + 32'd4);
            end
        end else begin
            n_cmp++;
            if (s_instra !== 32'h0) begin
                n_fail++;
                $display("FAIL sb_instra_zero: got %h expected 00000000", s_instra);
            end
        end
        if (s_req === 1'b1) begin
            n_cmp++;
            if (s_addr !== exp_pc) begin
                n_fail++;
                $display("FAIL sb_req_addr: got %h expected %h", s_addr, exp_pc);
            end
            n_cmp++;
            if (mem_pending && !imem_rvalid) begin
                n_fail++;
                $display("FAIL sb_outstanding: got req with pending expected no req");
            end
        end
        if (redir) begin
            n_cmp++;
            if (s_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL sb_redirect_squash: got %b expected 0", s_valid);
            end
        end

        if (redir) begin
            exp_pc = target_pc(tgt);
        end else if (s_valid === 1'b1 && !stall) begin
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end

        if (imem_rvalid) mem_pending = 1'b0;
        if (s_req === 1'b1 && imem_ready) begin
            mem_pending = 1'b1;
            mem_addr    = s_addr;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req);
        end
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid);
        end
        n_cmp++;
        if (instra !== 32'h0 || pc_plus4 !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h expected 0/0", instra, pc_plus4);
        end
        n_cmp++;
        if (fetch_stall !== 1'b1) begin
            n_fail++; $display("FAIL reset_fetch_stall: got %b expected 1", fetch_stall);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 32'h0;
    endtask

    task automatic test_zero_wait();
        logic        ev, er;
        logic [31:0] ea, e4;
        fixed_en   = 1'b1;
        fixed_word = 32'h0000_0013;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 32'h0, 100, 100);
            ev = (i >= 2) && (i % 2 == 0);
            er = (i % 2 == 1);
            ea = 32'(((i - 1) / 2) * 4);
            e4 = 32'((i / 2) * 4);
            n_cmp++;
            if (s_valid !== ev) begin
                n_fail++; $display("FAIL zw_valid[%0d]: got %b expected %b", i, s_valid, ev);
            end
            n_cmp++;
            if (s_req !== er) begin
                n_fail++; $display("FAIL zw_req[%0d]: got %b expected %b", i, s_req, er);
            end
            if (er) begin
                n_cmp++;
                if (s_addr !== ea) begin
                    n_fail++; $display("FAIL zw_addr[%0d]: got %h expected %h", i, s_addr, ea);
                end
            end
            if (ev) begin
                n_cmp++;
                if (s_pc4 !== e4 || s_instra !== 32'h0000_0013) begin
                    n_fail++;
                    $display("FAIL zw_data[%0d]: got %h/%h expected 00000013/%h",
                             i, s_instra, s_pc4, e4);
                end
            end
        end
    endtask

    task automatic test_stall();
        fixed_word = 32'h00A0_0093;
        step(1'b0, 1'b0, 32'h0, 100, 0);
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_000C) begin
            n_fail++; $display("FAIL stall_req: got %b/%h expected 1/0000000c", s_req, s_addr);
        end
        for (int k = 0; k < 4; k++) begin
            step((k < 3), 1'b0, 32'h0, 0, 100);
            n_cmp++;
            if (s_valid !== 1'b1 || s_instra !== 32'h00A0_0093 || s_pc4 !== 32'h10) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %b/%h/%h expected 1/00a00093/00000010",
                         k, s_valid, s_instra, s_pc4);
            end
            n_cmp++;
            if (s_req !== 1'b0) begin
                n_fail++; $display("FAIL stall_no_req[%0d]: got %b expected 0", k, s_req);
            end
        end
        step(1'b0, 1'b0, 32'h0, 100, 100);
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h10) begin
            n_fail++; $display("FAIL stall_next: got %b/%h expected 1/00000010", s_req, s_addr);
        end
    endtask

    task automatic test_redirect_wait();
        fixed_en = 1'b0;
        step(1'b0, 1'b1, 32'h0000_0100, 0, 0);
        step(1'b0, 1'b0, 32'h0, 0, 100);
        n_cmp++;
        if (s_valid !== 1'b0 || s_req !== 1'b0) begin
            n_fail++; $display("FAIL rw_drop: got %b/%b expected 0/0", s_valid, s_req);
        end
        step(1'b0, 1'b0, 32'h0, 100, 0);
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h100) begin
            n_fail++; $display("FAIL rw_target: got %b/%h expected 1/00000100", s_req, s_addr);
        end
        step(1'b0, 1'b0, 32'h0, 0, 100);
        n_cmp++;
        if (s_valid !== 1'b1 || s_instra !== mem_word(32'h100) || s_pc4 !== 32'h104) begin
            n_fail++;
            $display("FAIL rw_first: got %b/%h/%h expected 1/%h/00000104",
                     s_valid, s_instra, s_pc4, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_hold();
        step(1'b0, 1'b0, 32'h0, 100, 0);
        step(1'b1, 1'b0, 32'h0, 0, 100);
        n_cmp++;
        if (s_valid !== 1'b1) begin
            n_fail++; $display("FAIL rh_valid: got %b expected 1", s_valid);
        end
        step(1'b1, 1'b1, 32'h0000_0200, 0, 0);
        n_cmp++;
        if (s_valid !== 1'b0 || s_instra !== 32'h0) begin
            n_fail++; $display("FAIL rh_squash: got %b/%h expected 0/0", s_valid, s_instra);
        end
        step(1'b0, 1'b0, 32'h0, 0, 0);
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h200) begin
            n_fail++; $display("FAIL rh_target: got %b/%h expected 1/00000200", s_req, s_addr);
        end
    endtask

    task automatic test_ready_low();
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 32'h0, 0, 0);
            n_cmp++;
            if (s_req !== 1'b1 || s_addr !== 32'h200 || s_fstall !== 1'b1) begin
                n_fail++;
                $display("FAIL rl_hold[%0d]: got %b/%h/%b expected 1/00000200/1",
                         k, s_req, s_addr, s_fstall);
            end
        end
        step(1'b0, 1'b0, 32'h0, 100, 0);
        step(1'b0, 1'b0, 32'h0, 0, 100);
        n_cmp++;
        if (s_valid !== 1'b1 || s_pc4 !== 32'h204) begin
            n_fail++; $display("FAIL rl_resume: got %b/%h expected 1/00000204", s_valid, s_pc4);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 0, 0);
        step(1'b0, 1'b0, 32'h0, 100, 0);
        n_cmp++;
        if (s_addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_addr: got %h expected fffffffc", s_addr);
        end
        step(1'b0, 1'b0, 32'h0, 0, 100);
        n_cmp++;
        if (s_valid !== 1'b1 || s_pc4 !== 32'h0) begin
            n_fail++; $display("FAIL wrap_pc4: got %b/%h expected 1/00000000", s_valid, s_pc4);
        end
        step(1'b0, 1'b0, 32'h0, 100, 0);
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap_next: got %b/%h expected 1/00000000", s_req, s_addr);
        end
        step(1'b0, 1'b0, 32'h0, 0, 100);
    endtask

`ifdef FETCH_MISALIGN_CHK_EN
    task automatic test_misalign();
        step(1'b0, 1'b1, 32'h0000_0102, 0, 0);
        step(1'b0, 1'b0, 32'h0, 0, 0);
        n_cmp++;
        if (fetch_misalign !== 1'b1 || s_req !== 1'b1 || s_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL misalign: got %b/%b/%h expected 1/1/00000100",
                     fetch_misalign, s_req, s_addr);
        end
        step(1'b0, 1'b0, 32'h0, 0, 0);
        n_cmp++;
        if (fetch_misalign !== 1'b0) begin
            n_fail++; $display("FAIL misalign_clear: got %b expected 0", fetch_misalign);
        end
    endtask
`endif

    task automatic test_random();
        int          start;
        logic        st, rd;
        logic [31:0] t;
        start = consumed;
        for (int i = 0; i < 600; i++) begin
            st = ($urandom_range(99) < 30);
            rd = ($urandom_range(99) < 6);
            t  = $urandom;
            if ($urandom_range(7) != 0) t[1:0] = 2'b00;
            if ($urandom_range(9) == 0) t = 32'hFFFF_FFF8;
            step(st, rd, t, 60, 50);
        end
        n_cmp++;
        if (consumed - start < 30) begin
            n_fail++;
            $display("FAIL rand_progress: got %0d expected >= 30", consumed - start);
        end
    endtask

    task automatic test_reset_mid();
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            step(1'b0, 1'b0, 32'h0, 100, 100);
            hit = s_req;
        end
        n_cmp++;
        if (!hit) begin
            n_fail++; $display("FAIL rm_reach_req: got no request expected request in 20 cycles");
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_async: got %b/%b/%b expected 0/0/1", imem_req, instr_valid,
                     fetch_stall);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 32'h0;
        step(1'b0, 1'b0, 32'h0, 0, 100);
        n_cmp++;
        if (s_valid !== 1'b0 || s_req !== 1'b0) begin
            n_fail++; $display("FAIL rm_ignore: got %b/%b expected 0/0", s_valid, s_req);
        end
        step(1'b0, 1'b0, 32'h0, 100, 0);
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h0) begin
            n_fail++; $display("FAIL rm_req: got %b/%h expected 1/00000000", s_req, s_addr);
        end
        step(1'b0, 1'b0, 32'h0, 0, 100);
        n_cmp++;
        if (s_valid !== 1'b1 || s_instra !== mem_word(32'h0)) begin
            n_fail++;
            $display("FAIL rm_first: got %b/%h expected 1/%h", s_valid, s_instra,
                     mem_word(32'h0));
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_ready_low();
        test_wrap();
`ifdef FETCH_MISALIGN_CHK_EN
        test_misalign();
`endif
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
